step_driver_multi: RTL and testbench

Parametrised successor to the single-mode floppy head stepper driver. It debounces the step input, then advances a 3-bit phase index on each qualified step pulse to drive the four stepper coils. Drive mode is selectable: wave, two-phase full-step, or half-step. It also keeps an absolute track counter with end-stop clamping and a track-0 flag, and releases the coils after a configurable idle time.

---
 rtl/step_driver_multi.sv | 225 ++++++++++++++++++++++
 tb/tb_step_driver_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/step_driver_multi.sv
// step_driver_multi: debounced floppy head stepper with wave / full-step /
// half-step drive, absolute track counter with end-stop clamping, track-0 flag
// and optional coil release after a programmable idle time.
module step_driver_multi #(
    parameter int DEB_CYCLES     = 500,
    parameter int CNT_W          = 16,
    parameter int HALF_GAP       = 200,
    parameter int RELEASE_CYCLES = 0,
    parameter int MAX_TRACK      = 79,
    parameter int TRK_W          = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             dir,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [3:0]       coils,
    output logic [TRK_W-1:0] track,
    output logic             trk0,
    output logic             busy,
    output logic             step_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COUNT  = 3'd1,
        S_WAIT   = 3'd2,
        S_STEP_A = 3'd3,
        S_GAP    = 3'd4,
        S_STEP_B = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(HALF_GAP - 1);
    localparam logic [CNT_W-1:0] REL_CNT  = CNT_W'(RELEASE_CYCLES);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TRK_W-1:0] TRK_ZERO = {TRK_W{1'b0}};
    localparam logic [TRK_W-1:0] TRK_ONE  = TRK_W'(1);
    localparam logic [TRK_W-1:0] TRK_MAX  = TRK_W'(MAX_TRACK);

    // Phase index to coil pattern; all eight half-step positions.
    function automatic logic [3:0] decode(input logic [2:0] p);
        logic [3:0] c;
        case (p)
            3'd0:    c = 4'b0001;
            3'd1:    c = 4'b0011;
            3'd2:    c = 4'b0010;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0100;
            3'd5:    c = 4'b1100;
            3'd6:    c = 4'b1000;
            3'd7:    c = 4'b1001;
            default: c = 4'b0001;
        endcase
        return c;
    endfunction

    // Mode view of the phase: wave drops bit 0, full-step forces it, half uses p.
    function automatic logic [3:0] mode_coils(input logic [2:0] p, input logic [1:0] m);
        logic [3:0] c;
        case (m)
            2'b01:   c = decode(p | 3'b001);
            2'b10:   c = decode(p);
            default: c = decode(p & 3'b110);
        endcase
        return c;
    endfunction

    logic             r_step_meta, r_step_s, r_dir_meta, r_dir_s;
    state_t           r_state, w_state_nxt;
    logic [2:0]       r_p, w_p_nxt;
    logic [1:0]       r_mode, w_mode_nxt;
    logic             r_dir, w_dir_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_coils, w_coils_nxt;
    logic [TRK_W-1:0] r_track, w_track_nxt;
    logic             r_trk0, r_busy, r_done, w_done_nxt;

    logic             w_blocked, w_half;
    logic [2:0]       w_delta, w_p_a, w_p_b;
    logic [TRK_W-1:0] w_track_a;

    assign w_half    = (r_mode == 2'b10);
    assign w_delta   = w_half ? 3'd1 : 3'd2;
    assign w_blocked = r_dir_s ? (r_track == TRK_ZERO) : (r_track == TRK_MAX);
    assign w_p_a     = r_dir_s ? (r_p - w_delta) : (r_p + w_delta);
    assign w_track_a = r_dir_s ? (r_track - TRK_ONE) : (r_track + TRK_ONE);
    assign w_p_b     = r_dir ? (r_p - 3'd1) : (r_p + 3'd1);

    // Two-flop synchronizers for the asynchronous step and dir inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_step_meta <= 1'b1;
            r_step_s    <= 1'b1;
            r_dir_meta  <= 1'b1;
            r_dir_s     <= 1'b1;
        end else begin
            r_step_meta <= step;
            r_step_s    <= r_step_meta;
            r_dir_meta  <= dir;
            r_dir_s     <= r_dir_meta;
        end
    end

    // Next-state and datapath decisions for debounce, stepping, gap and release.
    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_mode_nxt  = r_mode;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_coils_nxt = r_coils;
        w_track_nxt = r_track;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mode_nxt = mode;
                if (en && !r_step_s) begin
                    w_state_nxt = S_COUNT;
                    w_cnt_nxt   = DEB_LOAD;
                    w_coils_nxt = mode_coils(r_p, r_mode);
                end else if ((RELEASE_CYCLES != 0) && (r_cnt != REL_CNT)) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                    if (r_cnt == REL_LAST) begin
                        w_coils_nxt = 4'b0000;
                    end else begin
                        w_coils_nxt = r_coils;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            S_COUNT: begin
                if (r_step_s) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_WAIT: begin
                if (r_step_s) begin
                    w_state_nxt = S_STEP_A;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_STEP_A: begin
                w_dir_nxt = r_dir_s;
                if (!w_blocked) begin
                    w_p_nxt     = w_p_a;
                    w_track_nxt = w_track_a;
                    w_coils_nxt = mode_coils(w_p_a, r_mode);
                end else begin
                    w_p_nxt = r_p;
                end
                if (!w_blocked && w_half) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = GAP_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_done_nxt  = 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = S_STEP_B;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_STEP_B: begin
                w_p_nxt     = w_p_b;
                w_coils_nxt = mode_coils(w_p_b, r_mode);
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, phase, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_p     <= 3'd0;
            r_mode  <= 2'b00;
            r_dir   <= 1'b0;
            r_cnt   <= CNT_ZERO;
            r_coils <= 4'b0001;
            r_track <= TRK_ZERO;
            r_trk0  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_mode  <= w_mode_nxt;
            r_dir   <= w_dir_nxt;
            r_cnt   <= w_cnt_nxt;
            r_coils <= w_coils_nxt;
            r_track <= w_track_nxt;
            r_trk0  <= (w_track_nxt == TRK_ZERO);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign coils     = r_coils;
    assign track     = r_track;
    assign trk0      = r_trk0;
    assign busy      = r_busy;
    assign step_done = r_done;

endmodule

// File: tb/tb_step_driver_multi.sv
// Bench for step_driver_multi: pulse-level expectation model plus literal pins.
module tb_step_driver_multi;

    localparam int DEB  = 4;
    localparam int HG   = 3;
    localparam int REL  = 10;
    localparam int MAXT = 5;
    localparam int TW   = 7;

    logic          clk = 1'b0;
    logic          rst, step, dir, en;
    logic [1:0]    mode;
    logic [3:0]    coils;
    logic [TW-1:0] track;
    logic          trk0, busy, step_done;

    step_driver_multi #(
        .DEB_CYCLES(DEB), .CNT_W(16), .HALF_GAP(HG), .RELEASE_CYCLES(REL),
        .MAX_TRACK(MAXT), .TRK_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .step(step), .dir(dir), .en(en), .mode(mode),
        .coils(coils), .track(track), .trk0(trk0), .busy(busy), .step_done(step_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Expected state of the drive as seen from outside.
    int         m_p, m_track, m_idle;
    logic [3:0] m_coils;
    bit         m_busy, m_done;

    logic [3:0] dec_tab [0:7] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0100, 4'b1100, 4'b1000, 4'b1001};

    function automatic logic [3:0] want_coils(input int p, input logic [1:0] md);
        case (md)
            2'b01:   return dec_tab[(p | 1) & 7];
            2'b10:   return dec_tab[p & 7];
            default: return dec_tab[p & 6];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: outputs against the expectation model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("coils", 32'(coils), 32'(m_coils));
            chk("track", 32'(track), 32'(m_track));
            chk("trk0", 32'(trk0), 32'(m_track == 0));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("step_done", 32'(step_done), 32'(m_done));
        end
    end

    task automatic reset_model();
        m_p = 0; m_track = 0; m_idle = 0;
        m_coils = 4'b0001; m_busy = 1'b0; m_done = 1'b0;
    endtask

    // One clock spent idle: release timer advances, done pulse ends.
    task automatic idle_model();
        m_done = 1'b0;
        if (m_idle < REL) begin
            m_idle++;
            if (m_idle == REL) m_coils = 4'b0000;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            idle_model();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        reset_model();
        rst = 1'b1;
    endtask

    // Low pulse of len clocks on step with direction d. Edge k counts from the
    // first clock after step falls; the FSM sees the low from edge 3, the first
    // coil move lands on edge len+4. abort_k>0 resets the DUT on that edge.
    task automatic pulse(input int len, input logic d, input int abort_k);
        bit acc, blk, half;
        int e3, last;
        dir  = d;
        step = 1'b0;
        acc  = en && (len >= DEB + 1);
        half = (mode == 2'b10);
        blk  = d ? (m_track == 0) : (m_track == MAXT);
        e3   = len + 4;
        if (!en)               last = len + 4;
        else if (!acc)         last = len + 3;
        else if (half && !blk) last = e3 + HG + 1;
        else                   last = e3;
        for (int k = 1; k <= last; k++) begin
            tick();
            if (k == len) step = 1'b1;
            if (k == abort_k) begin
                reset_model();
                rst = 1'b1;
                break;
            end
            if (!en || k < 3) begin
                idle_model();
            end else if (k == 3) begin
                m_idle  = 0;
                m_coils = want_coils(m_p, mode);
                m_busy  = 1'b1;
                m_done  = 1'b0;
            end else if (!acc) begin
                if (k == len + 3) begin
                    m_busy = 1'b0;
                    m_idle = 0;
                end
            end else if (k == e3) begin
                if (!blk) begin
                    m_p     = (m_p + (half ? (d ? 7 : 1) : (d ? 6 : 2))) % 8;
                    m_track = m_track + (d ? -1 : 1);
                    m_coils = want_coils(m_p, mode);
                end
                if (blk || !half) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_idle = 0;
                end
            end else if (k == e3 + HG + 1) begin
                m_p     = (m_p + (d ? 7 : 1)) % 8;
                m_coils = want_coils(m_p, mode);
                m_done  = 1'b1;
                m_busy  = 1'b0;
                m_idle  = 0;
            end
            if (abort_k != 0 && k == abort_k - 1) rst = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; step = 1'b1; dir = 1'b0; en = 1'b1; mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        reset_model();
        chk_en = 1'b1;
        chk("rst_coils", 32'(coils), 32'h1);
        chk("rst_track", 32'(track), 32'd0);
        chk("rst_trk0", 32'(trk0), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(step_done), 32'd0);

        // Debounce: 4 low samples rejected, 5 accepted.
        pulse(4, 1'b0, 0);
        chk("deb_rej_coils", 32'(coils), 32'h1);
        chk("deb_rej_track", 32'(track), 32'd0);
        pulse(5, 1'b0, 0);
        chk("deb_acc_coils", 32'(coils), 32'h2);
        chk("deb_acc_track", 32'(track), 32'd1);

        // Wave wrap.
        pulse(5, 1'b0, 0);
        chk("wave2", 32'(coils), 32'h4);
        pulse(5, 1'b0, 0);
        chk("wave3", 32'(coils), 32'h8);
        pulse(5, 1'b0, 0);
        chk("wave4", 32'(coils), 32'h1);
        chk("wave4_track", 32'(track), 32'd4);
        pulse(6, 1'b1, 0);
        chk("wave_out", 32'(coils), 32'h8);
        chk("wave_out_track", 32'(track), 32'd3);

        // Clamp at the top end-stop.
        pulse(5, 1'b0, 0);
        pulse(5, 1'b0, 0);
        chk("top_track", 32'(track), 32'd5);
        pulse(5, 1'b0, 0);
        chk("top_clamp_coils", 32'(coils), 32'h2);
        chk("top_clamp_track", 32'(track), 32'd5);

        // Release, then restore on the next accepted low in full-step mode.
        run_idle(12);
        chk("released", 32'(coils), 32'h0);
        mode = 2'b01;
        run_idle(2);
        pulse(5, 1'b1, 0);
        chk("full_out_coils", 32'(coils), 32'h3);
        chk("full_out_track", 32'(track), 32'd4);

        // Full-step from reset.
        do_reset();
        mode = 2'b01;
        pulse(5, 1'b0, 0);
        chk("full_coils", 32'(coils), 32'h6);
        chk("full_track", 32'(track), 32'd1);

        // Half-step from reset.
        do_reset();
        mode = 2'b10;
        pulse(5, 1'b0, 0);
        chk("half_coils", 32'(coils), 32'h2);
        chk("half_track", 32'(track), 32'd1);

        // Clamp at track 0.
        do_reset();
        mode = 2'b00;
        pulse(5, 1'b1, 0);
        chk("zero_clamp_coils", 32'(coils), 32'h1);
        chk("zero_clamp_trk0", 32'(trk0), 32'd1);

        // Reset in the middle of the half-step gap.
        mode = 2'b10;
        pulse(5, 1'b0, 11);
        chk("abort_coils", 32'(coils), 32'h1);
        chk("abort_track", 32'(track), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(step_done), 32'd0);
        run_idle(2);

        // Disabled drive ignores a long pulse.
        en = 1'b0;
        pulse(8, 1'b0, 0);
        chk("en0_track", 32'(track), 32'd0);
        chk("en0_busy", 32'(busy), 32'd0);
        en = 1'b1;
        run_idle(3);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
